// File: rtl/alu_commit.sv
// ---------------------------------------------------------------------------
// alu_commit
//   Stage directly downstream of the ALU. Merges each accepted ALU flag
//   vector into the architectural PSW under a per-op mask, queues register
//   results in a 2-entry in-order FIFO for the writeback port, and owns the
//   direct PSW writers (POPF-style load and CLC/STC/CMC).
//
// Parameters
//   PSW_RESET    PSW value after reset
//   FIFO_DEPTH   result queue entries (only 2 is supported)
//
// Ports
//   clk, reset         clock; synchronous active-high reset
//   flush              drop queued results, PSW untouched
//   in_valid/in_ready  ALU result handshake
//   in_result/in_size/in_flags/in_flag_mask/in_wb/in_dest  ALU result fields
//                      (flag index AC=0 CY=1 V=2 P=3 S=4 Z=5)
//   wb_valid/wb_ready  writeback handshake for the queue head
//   wb_data/wb_size/wb_dest  queue head fields (registered)
//   psw_wr_en/psw_wr_data    PSW load
//   cy_op              0 none, 1 clear CY, 2 set CY, 3 complement CY
//   psw                architectural PSW
//   psw_fwd            PSW seen by the decoder
//   count              queued entries 0..2
//
// Configuration
//   ALU_COMMIT_PSW_BYPASS_EN  defined: psw_fwd is the combinational next PSW;
//                             undefined: psw_fwd equals psw.
// ---------------------------------------------------------------------------
module alu_commit #(
    parameter logic [15:0] PSW_RESET  = 16'hF002,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_result,
    input  logic        in_size,
    input  logic [5:0]  in_flags,
    input  logic [5:0]  in_flag_mask,
    input  logic        in_wb,
    input  logic [3:0]  in_dest,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [15:0] wb_data,
    output logic        wb_size,
    output logic [3:0]  wb_dest,
    input  logic        psw_wr_en,
    input  logic [15:0] psw_wr_data,
    input  logic [1:0]  cy_op,
    output logic [15:0] psw,
    output logic [15:0] psw_fwd,
    output logic [1:0]  count
);

    localparam logic [15:0] PSW_WMASK = 16'h0FD5;
    localparam logic [15:0] PSW_ONES  = 16'hF002;
    localparam logic [2:0]  DEPTH     = 3'(FIFO_DEPTH);

    // PSW bit positions of the ALU flags
    localparam int unsigned B_CY = 0;
    localparam int unsigned B_P  = 2;
    localparam int unsigned B_AC = 4;
    localparam int unsigned B_Z  = 6;
    localparam int unsigned B_S  = 7;
    localparam int unsigned B_V  = 11;

    typedef enum logic [1:0] {
        Q_EMPTY = 2'd0,
        Q_ONE   = 2'd1,
        Q_FULL  = 2'd2
    } q_state_t;

    q_state_t    q_state;
    q_state_t    q_next;

    logic [15:0] head_data;
    logic        head_size;
    logic [3:0]  head_dest;
    logic [15:0] tail_data;
    logic        tail_size;
    logic [3:0]  tail_dest;

    logic        accept;
    logic        push;
    logic        pop;
    logic        load_head_new;
    logic        load_head_tail;
    logic        load_tail_new;
    logic [15:0] psw_next;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    assign count    = q_state;
    assign in_ready = !reset && !flush && !psw_wr_en && (cy_op == 2'd0)
                      && ({1'b0, count} < DEPTH);
    assign accept   = in_valid && in_ready;
    assign push     = accept && in_wb;
    assign pop      = wb_valid && wb_ready && !flush;

    assign wb_valid = (q_state != Q_EMPTY);
    assign wb_data  = head_data;
    assign wb_size  = head_size;
    assign wb_dest  = head_dest;

    // ------------------------------------------------------------------
    // Queue occupancy: the head register drives wb_* directly, the tail
    // register only holds the second entry. A pop from FULL shifts the tail
    // into the head; push+pop on ONE reloads the head with the new entry.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            q_state <= Q_EMPTY;
        end else begin
            q_state <= q_next;
        end
    end

    always_comb begin
        q_next         = q_state;
        load_head_new  = 1'b0;
        load_head_tail = 1'b0;
        load_tail_new  = 1'b0;
        if (flush) begin
            q_next = Q_EMPTY;
        end else begin
            case (q_state)
                Q_EMPTY: begin
                    if (push) begin
                        q_next        = Q_ONE;
                        load_head_new = 1'b1;
                    end
                end
                Q_ONE: begin
                    case ({push, pop})
                        2'b10: begin
                            q_next        = Q_FULL;
                            load_tail_new = 1'b1;
                        end
                        2'b01: begin
                            q_next = Q_EMPTY;
                        end
                        2'b11: begin
                            load_head_new = 1'b1;
                        end
                        default: begin
                            q_next = Q_ONE;
                        end
                    endcase
                end
                Q_FULL: begin
                    // in_ready is low while full, so no push can arrive here
                    if (pop) begin
                        q_next         = Q_ONE;
                        load_head_tail = 1'b1;
                    end
                end
                default: begin
                    q_next = Q_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_data <= '0;
            head_size <= 1'b0;
            head_dest <= '0;
            tail_data <= '0;
            tail_size <= 1'b0;
            tail_dest <= '0;
        end else begin
            if (load_head_new) begin
                head_data <= in_result;
                head_size <= in_size;
                head_dest <= in_dest;
            end else if (load_head_tail) begin
                head_data <= tail_data;
                head_size <= tail_size;
                head_dest <= tail_dest;
            end
            if (load_tail_new) begin
                tail_data <= in_result;
                tail_size <= in_size;
                tail_dest <= in_dest;
            end
        end
    end

    // ------------------------------------------------------------------
    // PSW: load beats cy_op; either one stalls the ALU, so the flag merge
    // never competes with them.
    // ------------------------------------------------------------------
    always_comb begin
        psw_next = psw;
        if (psw_wr_en) begin
            psw_next = (psw_wr_data & PSW_WMASK) | PSW_ONES;
        end else if (cy_op != 2'd0) begin
            case (cy_op)
                2'd1:    psw_next[B_CY] = 1'b0;
                2'd2:    psw_next[B_CY] = 1'b1;
                default: psw_next[B_CY] = ~psw[B_CY];
            endcase
        end else if (accept) begin
            if (in_flag_mask[0]) psw_next[B_AC] = in_flags[0];
            if (in_flag_mask[1]) psw_next[B_CY] = in_flags[1];
            if (in_flag_mask[2]) psw_next[B_V]  = in_flags[2];
            if (in_flag_mask[3]) psw_next[B_P]  = in_flags[3];
            if (in_flag_mask[4]) psw_next[B_S]  = in_flags[4];
            if (in_flag_mask[5]) psw_next[B_Z]  = in_flags[5];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            psw <= PSW_RESET;
        end else begin
            psw <= psw_next;
        end
    end

`ifdef ALU_COMMIT_PSW_BYPASS_EN
    assign psw_fwd = psw_next;
`else
    assign psw_fwd = psw;
`endif

endmodule

// File: tb/tb_alu_commit.sv
module tb_alu_commit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_result = '0;
    logic        in_size = 1'b0;
    logic [5:0]  in_flags = '0;
    logic [5:0]  in_flag_mask = '0;
    logic        in_wb = 1'b0;
    logic [3:0]  in_dest = '0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [15:0] wb_data;
    logic        wb_size;
    logic [3:0]  wb_dest;
    logic        psw_wr_en = 1'b0;
    logic [15:0] psw_wr_data = '0;
    logic [1:0]  cy_op = '0;
    logic [15:0] psw;
    logic [15:0] psw_fwd;
    logic [1:0]  count;

    alu_commit #(.PSW_RESET(16'hF002), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_size(in_size), .in_flags(in_flags), .in_flag_mask(in_flag_mask),
        .in_wb(in_wb), .in_dest(in_dest),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_size(wb_size), .wb_dest(wb_dest),
        .psw_wr_en(psw_wr_en), .psw_wr_data(psw_wr_data), .cy_op(cy_op),
        .psw(psw), .psw_fwd(psw_fwd), .count(count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [20:0] sb[$];           // {data, size, dest}, head first
    logic [15:0] psw_m = 16'hF002;
    bit          chk_en = 1'b0;
    bit          was_reset = 1'b0;
    bit          lit_en = 1'b0;
    logic [15:0] lit_psw = '0;
    int          flag_pos[6] = '{4, 0, 11, 2, 7, 6};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes a writeback
    always @(negedge clk) begin
        if (!reset && !flush && wb_valid === 1'b1 && wb_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got %0h expected none", {wb_data, wb_size, wb_dest});
            end else begin
                logic [20:0] e;
                e = sb.pop_front();
                if ({wb_data, wb_size, wb_dest} !== e) begin
                    errors++;
                    $display("FAIL wb_entry: got %0h expected %0h", {wb_data, wb_size, wb_dest}, e);
                end
            end
        end
    end

    task automatic check_state();
        chk("psw", psw, psw_m);
        chk("count", count, sb.size());
        chk("wb_valid", wb_valid, sb.size() != 0);
        if (sb.size() != 0) chk("wb_head", {wb_data, wb_size, wb_dest}, sb[0]);
        if (was_reset) chk("wb_reset_fields", {wb_data, wb_size, wb_dest}, 0);
        if (lit_en) begin
            chk("psw_literal", psw, lit_psw);
            lit_en = 1'b0;
        end
    endtask

    task automatic cyc(input bit r, input bit fl, input bit iv, input logic [15:0] res,
                       input bit sz, input logic [5:0] fg, input logic [5:0] mk,
                       input bit wbf, input logic [3:0] dst, input bit wr,
                       input logic [15:0] wd, input logic [1:0] cy, input bit rdy);
        bit exp_ready;
        logic [15:0] nxt;
        @(posedge clk);
        #1;
        if (chk_en) check_state();
        chk_en = 1'b1;
        #1;
        reset = r; flush = fl; in_valid = iv; in_result = res; in_size = sz;
        in_flags = fg; in_flag_mask = mk; in_wb = wbf; in_dest = dst;
        psw_wr_en = wr; psw_wr_data = wd; cy_op = cy; wb_ready = rdy;
        exp_ready = !r && !fl && !wr && (cy == 2'd0) && (sb.size() < 2);
        nxt = psw_m;
        if (wr) begin
            nxt = (wd & 16'h0FD5) | 16'hF002;
        end else if (cy == 2'd1) begin
            nxt[0] = 1'b0;
        end else if (cy == 2'd2) begin
            nxt[0] = 1'b1;
        end else if (cy == 2'd3) begin
            nxt[0] = !psw_m[0];
        end else if (exp_ready && iv) begin
            for (int i = 0; i < 6; i++) if (mk[i]) nxt[flag_pos[i]] = fg[i];
        end
        #1;
        chk("in_ready", in_ready, exp_ready);
        if (!r) begin
`ifdef ALU_COMMIT_PSW_BYPASS_EN
            chk("psw_fwd", psw_fwd, nxt);
`else
            chk("psw_fwd", psw_fwd, psw_m);
`endif
        end
        if (r) begin
            sb.delete();
            psw_m = 16'hF002;
        end else begin
            if (fl) sb.delete();
            if (exp_ready && iv && wbf) sb.push_back({res, sz, dst});
            psw_m = nxt;
        end
        was_reset = r;
    endtask

    task automatic idle(input bit rdy);
        cyc(0, 0, 0, 16'h0, 0, 6'h0, 6'h0, 0, 4'h0, 0, 16'h0, 2'd0, rdy);
    endtask

    task automatic alu(input logic [15:0] res, input logic [5:0] fg, input logic [5:0] mk,
                       input bit wbf, input logic [3:0] dst, input bit rdy);
        cyc(0, 0, 1, res, 1, fg, mk, wbf, dst, 0, 16'h0, 2'd0, rdy);
    endtask

    initial begin
        // 1: reset for two cycles
        cyc(1, 0, 0, 16'h0, 0, 6'h0, 6'h0, 0, 4'h0, 0, 16'h0, 2'd0, 0);
        cyc(1, 0, 0, 16'h0, 0, 6'h0, 6'h0, 0, 4'h0, 0, 16'h0, 2'd0, 0);
        lit_en = 1'b1; lit_psw = 16'hF002;
        idle(0);
        // 2: full-mask merge and enqueue
        alu(16'h0000, 6'b101010, 6'h3F, 1, 4'h3, 0);
        lit_en = 1'b1; lit_psw = 16'hF047;
        idle(0);
        idle(1);
        // 3: STC then INC-style merge keeping CY
        cyc(0, 0, 0, 16'h0, 0, 6'h0, 6'h0, 0, 4'h0, 0, 16'h0, 2'd2, 0);
        alu(16'h1234, 6'b000000, 6'b111101, 0, 4'h1, 0);
        lit_en = 1'b1; lit_psw = 16'hF003;
        // 4: fill, attempt a third, drain in order
        alu(16'hAAAA, 6'h00, 6'h00, 1, 4'h5, 0);
        alu(16'hBBBB, 6'h00, 6'h00, 1, 4'h6, 0);
        alu(16'hCCCC, 6'h3F, 6'h3F, 1, 4'h7, 0);
        idle(1);
        idle(1);
        idle(1);
        // 5: load has priority over cy_op, then CMC twice
        cyc(0, 0, 1, 16'h5555, 0, 6'h3F, 6'h3F, 1, 4'h2, 1, 16'hFFFF, 2'd3, 0);
        lit_en = 1'b1; lit_psw = 16'hFFD7;
        cyc(0, 0, 0, 16'h0, 0, 6'h0, 6'h0, 0, 4'h0, 0, 16'h0, 2'd3, 0);
        lit_en = 1'b1; lit_psw = 16'hFFD6;
        cyc(0, 0, 0, 16'h0, 0, 6'h0, 6'h0, 0, 4'h0, 0, 16'h0, 2'd3, 0);
        lit_en = 1'b1; lit_psw = 16'hFFD7;
        // 6: flush while full with wb_ready high
        alu(16'h1111, 6'h00, 6'h01, 1, 4'h8, 0);
        alu(16'h2222, 6'h00, 6'h00, 1, 4'h9, 0);
        cyc(0, 1, 0, 16'h0, 0, 6'h0, 6'h0, 0, 4'h0, 0, 16'h0, 2'd0, 1);
        idle(1);
        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            bit r, fl, iv, wbf, wr, rdy, sz;
            logic [1:0] cy;
            r   = ($urandom_range(0, 149) == 0);
            fl  = ($urandom_range(0, 19) == 0);
            wr  = ($urandom_range(0, 15) == 0);
            cy  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            iv  = ($urandom_range(0, 9) < 7);
            wbf = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 9) < 6);
            sz  = 1'($urandom);
            cyc(r, fl, iv, 16'($urandom), sz, 6'($urandom), 6'($urandom), wbf,
                4'($urandom), wr, 16'($urandom), cy, rdy);
        end
        idle(1);
        idle(1);
        idle(1);
        @(posedge clk);
        #1;
        check_state();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
